// File: rtl/sfp_pkg.sv
// Shared helpers for the row normaliser: width derivation, lane slicing and
// the divide-by-zero saturation value.
package sfp_pkg;

    // Default parameter values for the attention datapath instance.
    localparam int COL_DEF   = 8;
    localparam int BW_DEF    = 8;
    localparam int SHIFT_DEF = 7;
    localparam int DEPTH_DEF = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A lane-abs sum needs room for COL maximal magnitudes without overflow.
    function automatic int sum_width(input int bw_psum, input int col);
        return bw_psum + clog2(col);
    endfunction

    // Bit offset of a lane inside a packed lane vector.
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    // Largest positive two's-complement value of a w-bit lane.
    function automatic logic [63:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/sfp_row_norm_if.sv
// Request/response bundle of the row normaliser. The master side is the
// datapath controller (and peer core link); the slave side is the normaliser.
interface sfp_row_norm_if #(
    parameter int COL     = 8,
    parameter int BW_PSUM = 20,
    parameter int SUM_W   = 23,
    parameter int CW      = 5
) ();
    logic                   acc;
    logic                   div;
    logic                   sign_mode;
    logic [COL*BW_PSUM-1:0] sfp_in;
    logic [SUM_W-1:0]       sum_in;
    logic                   sum_in_valid;
    logic                   ext_rd;
    logic [SUM_W-1:0]       sum_out;
    logic                   sum_out_valid;
    logic                   acc_ready;
    logic [COL*BW_PSUM-1:0] sfp_out;
    logic                   out_valid;
    logic                   dz_flag;
    logic                   div_err;
    logic                   ovf;
    // Occupancy of the local and external sum FIFOs, for observation.
    logic [CW-1:0]          loc_cnt;
    logic [CW-1:0]          ext_cnt;

    modport master (
        output acc, div, sign_mode, sfp_in, sum_in, sum_in_valid, ext_rd,
        input  sum_out, sum_out_valid, acc_ready, sfp_out, out_valid,
               dz_flag, div_err, ovf, loc_cnt, ext_cnt
    );

    modport slave (
        input  acc, div, sign_mode, sfp_in, sum_in, sum_in_valid, ext_rd,
        output sum_out, sum_out_valid, acc_ready, sfp_out, out_valid,
               dz_flag, div_err, ovf, loc_cnt, ext_cnt
    );
endinterface

// File: rtl/sfp_sum_fifo.sv
// First-word fall-through FIFO for row sums. Push is ignored when full and
// pop is ignored when empty, so callers may assert either unconditionally.
// The head reads as zero while empty.
module sfp_sum_fifo
    import sfp_pkg::*;
#(
    parameter  int W     = 23,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/sfp_row_norm.sv
// Softmax-style row normaliser: accumulates the lane-abs sum of a psum row
// into a local FIFO and an external FIFO for the peer core, then divides each
// lane by the shifted sum of both cores' row sums.
module sfp_row_norm
    import sfp_pkg::*;
#(
    parameter  int COL     = COL_DEF,
    parameter  int BW      = BW_DEF,
    parameter  int BW_PSUM = 2 * BW + 4,
    parameter  int SHIFT   = SHIFT_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    localparam int SUM_W   = sum_width(BW_PSUM, COL),
    localparam int CW      = clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           reset,
    sfp_row_norm_if.slave  bus
);

    localparam logic [BW_PSUM-1:0] SAT = BW_PSUM'(sat_pos(BW_PSUM));

    logic [COL*BW_PSUM-1:0] abs_all;
    logic [COL*BW_PSUM-1:0] sfp_next;
    logic [SUM_W-1:0]       lane_sum;
    logic [SUM_W-1:0]       loc_head;
    logic                   loc_empty;
    logic                   loc_full;
    logic                   ext_empty;
    logic                   ext_full;
    logic                   acc_ready;
    logic                   push;
    logic                   div_ok;
    logic [SUM_W:0]         d_sum;
    logic                   d_zero;
    logic                   d_hi;

    logic [COL*BW_PSUM-1:0] sfp_out_r;
    logic                   out_valid_r;
    logic                   dz_flag_r;
    logic                   div_err_r;
    logic                   ovf_r;

    // Readiness is taken before any same-cycle pop, so a full FIFO rejects acc+div pushes.
    assign acc_ready = !loc_full && !ext_full;
    assign push      = bus.acc && acc_ready;
    assign div_ok    = bus.div && !loc_empty && bus.sum_in_valid;

    // One extra bit keeps the two shifted sums from wrapping.
    assign d_sum  = (SUM_W+1)'(loc_head >> SHIFT) + (SUM_W+1)'(bus.sum_in >> SHIFT);
    assign d_zero = (d_sum == '0);
    // A denominator wider than a lane always yields a zero quotient.
    assign d_hi   = |d_sum[SUM_W:BW_PSUM];

    for (genvar i = 0; i < COL; i++) begin : g_lane
        logic [BW_PSUM-1:0] x;
        logic [BW_PSUM-1:0] mag;
        logic [BW_PSUM-1:0] q;
        logic [BW_PSUM-1:0] y;

        assign x   = bus.sfp_in[lane_lo(i, BW_PSUM) +: BW_PSUM];
        // The most negative input negates onto itself, which read unsigned is its exact magnitude.
        assign mag = x[BW_PSUM-1] ? (~x + BW_PSUM'(1)) : x;
        assign q   = d_zero ? ((mag != '0) ? SAT : '0)
                            : (d_hi ? '0 : mag / d_sum[BW_PSUM-1:0]);
        assign y   = (bus.sign_mode && x[BW_PSUM-1]) ? (~q + BW_PSUM'(1)) : q;

        assign abs_all[lane_lo(i, BW_PSUM) +: BW_PSUM]  = mag;
        assign sfp_next[lane_lo(i, BW_PSUM) +: BW_PSUM] = y;
    end

    // Row sum of lane magnitudes.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < COL; i++) begin
            lane_sum = lane_sum + SUM_W'(abs_all[i*BW_PSUM +: BW_PSUM]);
        end
    end

    sfp_sum_fifo #(.W(SUM_W), .DEPTH(DEPTH)) u_loc_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (div_ok),
        .din   (lane_sum),
        .dout  (loc_head),
        .empty (loc_empty),
        .full  (loc_full),
        .count (bus.loc_cnt)
    );

    sfp_sum_fifo #(.W(SUM_W), .DEPTH(DEPTH)) u_ext_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (bus.ext_rd),
        .din   (lane_sum),
        .dout  (bus.sum_out),
        .empty (ext_empty),
        .full  (ext_full),
        .count (bus.ext_cnt)
    );

    // Result, status and error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sfp_out_r   <= '0;
            out_valid_r <= 1'b0;
            dz_flag_r   <= 1'b0;
            div_err_r   <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            out_valid_r <= div_ok;
            div_err_r   <= bus.div && !div_ok;
            if (bus.acc && !acc_ready) ovf_r <= 1'b1;
            if (div_ok) begin
                sfp_out_r <= sfp_next;
                dz_flag_r <= d_zero;
            end
        end
    end

    assign bus.acc_ready     = acc_ready;
    assign bus.sum_out_valid = !ext_empty;
    assign bus.sfp_out       = sfp_out_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.dz_flag       = dz_flag_r;
    assign bus.div_err       = div_err_r;
    assign bus.ovf           = ovf_r;

endmodule

// File: tb/tb_sfp_row_norm.sv
// Randomised and directed bench for sfp_row_norm against a queue-based model.
module tb_sfp_row_norm;

    localparam int COL   = 8;
    localparam int BWP   = 20;
    localparam int SUM_W = 23;
    localparam int DEPTH = 16;
    localparam int SHIFT = 7;

    logic clk;
    logic reset;

    sfp_row_norm_if #(.COL(COL), .BW_PSUM(BWP), .SUM_W(SUM_W), .CW(5)) bus ();

    sfp_row_norm #(.COL(COL), .BW(8), .BW_PSUM(BWP), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state
    longint      loc_q[$];
    longint      ext_q[$];
    bit          m_ovf;
    bit          m_dz;
    logic [19:0] m_out [COL];
    int          cur_lanes [COL];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rand_lane();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return int'($urandom_range(0, 4094)) - 2047;
            2:       return int'($urandom_range(0, 1048575)) - 524288;
            default: return -524288;
        endcase
    endfunction

    task automatic rand_lanes();
        for (int i = 0; i < COL; i++) cur_lanes[i] = rand_lane();
    endtask

    task automatic set_lanes(input int v);
        for (int i = 0; i < COL; i++) cur_lanes[i] = v;
    endtask

    task automatic model_clear();
        loc_q.delete();
        ext_q.delete();
        m_ovf = 1'b0;
        m_dz  = 1'b0;
        for (int i = 0; i < COL; i++) m_out[i] = '0;
    endtask

    // One clock: drive at negedge, predict, check just after the rising edge.
    task automatic step(input bit a, input bit d, input bit e, input bit sm,
                        input bit siv, input logic [SUM_W-1:0] si);
        longint absv [COL];
        longint s, head, den, q, val;
        bit     ready, acc_ok, div_ok, exp_err;
        @(negedge clk);
        bus.acc          = a;
        bus.div          = d;
        bus.ext_rd       = e;
        bus.sign_mode    = sm;
        bus.sum_in_valid = siv;
        bus.sum_in       = si;
        for (int i = 0; i < COL; i++) bus.sfp_in[i*BWP +: BWP] = 20'(cur_lanes[i]);

        s = 0;
        for (int i = 0; i < COL; i++) begin
            absv[i] = (cur_lanes[i] < 0) ? -longint'(cur_lanes[i]) : longint'(cur_lanes[i]);
            s += absv[i];
        end
        ready  = (loc_q.size() < DEPTH) && (ext_q.size() < DEPTH);
        acc_ok = a && ready;
        if (a && !ready) m_ovf = 1'b1;
        div_ok  = d && (loc_q.size() > 0) && siv;
        exp_err = d && !div_ok;
        if (div_ok) begin
            head = loc_q.pop_front();
            den  = (head / (1 << SHIFT)) + (longint'(si) / (1 << SHIFT));
            m_dz = (den == 0);
            for (int i = 0; i < COL; i++) begin
                if (den == 0) q = (absv[i] != 0) ? 524287 : 0;
                else          q = absv[i] / den;
                val = (sm && cur_lanes[i] < 0) ? -q : q;
                m_out[i] = 20'(val);
            end
        end
        if (e && ext_q.size() > 0) void'(ext_q.pop_front());
        if (acc_ok) begin
            loc_q.push_back(s);
            ext_q.push_back(s);
        end

        @(posedge clk);
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(div_ok));
        chk("div_err", 64'(bus.div_err), 64'(exp_err));
        chk("ovf", 64'(bus.ovf), 64'(m_ovf));
        chk("dz_flag", 64'(bus.dz_flag), 64'(m_dz));
        chk("acc_ready", 64'(bus.acc_ready),
            64'((loc_q.size() < DEPTH) && (ext_q.size() < DEPTH)));
        chk("sum_out_valid", 64'(bus.sum_out_valid), 64'(ext_q.size() > 0));
        chk("sum_out", 64'(bus.sum_out), (ext_q.size() > 0) ? 64'(ext_q[0]) : 64'd0);
        chk("loc_cnt", 64'(bus.loc_cnt), 64'(loc_q.size()));
        chk("ext_cnt", 64'(bus.ext_cnt), 64'(ext_q.size()));
        for (int i = 0; i < COL; i++)
            chk($sformatf("lane%0d", i), 64'(bus.sfp_out[i*BWP +: BWP]), 64'(m_out[i]));
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (loc_q.size() == 0 && ext_q.size() == 0) break;
            rand_lanes();
            step(1'b0, loc_q.size() > 0, ext_q.size() > 0, 1'b1, 1'b1, 23'($urandom_range(0, 65535)));
        end
    endtask

    task automatic rand_phase(input int n);
        for (int k = 0; k < n; k++) begin
            rand_lanes();
            step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) != 0,
                 ($urandom_range(0, 3) == 0) ? 23'($urandom_range(0, 255))
                                             : 23'($urandom_range(0, 1 << 22)));
        end
    endtask

    task automatic idle_inputs();
        bus.acc          = 1'b0;
        bus.div          = 1'b0;
        bus.ext_rd       = 1'b0;
        bus.sign_mode    = 1'b0;
        bus.sum_in_valid = 1'b0;
        bus.sum_in       = '0;
        bus.sfp_in       = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_clear();
        set_lanes(0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_acc_ready", 64'(bus.acc_ready), 64'd1);
        chk("rst_sum_out_valid", 64'(bus.sum_out_valid), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);

        // Signed and unsigned normalisation, D = 128
        set_lanes(1024);
        cur_lanes[3] = -1024;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("t2_sum_out", 64'(bus.sum_out), 64'd8192);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 23'd8192);
        chk("t2_lane0", 64'(bus.sfp_out[0 +: BWP]), 64'd8);
        chk("t2_lane3_signed", 64'(bus.sfp_out[3*BWP +: BWP]), 64'hFFFF8);
        chk("t2_dz", 64'(bus.dz_flag), 64'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 23'd8192);
        chk("t2_lane3_unsigned", 64'(bus.sfp_out[3*BWP +: BWP]), 64'd8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("t2_hold_lane3", 64'(bus.sfp_out[3*BWP +: BWP]), 64'd8);

        // Zero denominator saturation
        set_lanes(0);
        cur_lanes[0] = 100;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cur_lanes[0] = 5;
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 23'd100);
        chk("t3_lane0_sat", 64'(bus.sfp_out[0 +: BWP]), 64'd524287);
        chk("t3_lane1_zero", 64'(bus.sfp_out[BWP +: BWP]), 64'd0);
        chk("t3_dz", 64'(bus.dz_flag), 64'd1);

        // Rejected divides
        drain();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 23'd500);
        chk("t5_empty_div_err", 64'(bus.div_err), 64'd1);
        rand_lanes();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'd500);
        chk("t5_nosum_div_err", 64'(bus.div_err), 64'd1);
        chk("t5_nosum_cnt", 64'(bus.loc_cnt), 64'd1);

        // Fill, overflow, ordered drain
        drain();
        set_lanes(0);
        for (int k = 0; k < DEPTH; k++) begin
            cur_lanes[0] = (k + 1) * 128;
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        end
        chk("t4_full_ready", 64'(bus.acc_ready), 64'd0);
        cur_lanes[0] = 99999;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("t4_ovf", 64'(bus.ovf), 64'd1);
        cur_lanes[0] = 10000;
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
            chk($sformatf("t4_order%0d", k), 64'(bus.sfp_out[0 +: BWP]), 64'(10000 / (k + 1)));
        end

        // Most negative lanes, acc+div on empty local FIFO
        drain();
        set_lanes(-524288);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 23'd1000);
        chk("t6_sum_out", 64'(bus.sum_out), 64'd4194304);
        chk("t6_div_err", 64'(bus.div_err), 64'd1);
        chk("t6_loc_cnt", 64'(bus.loc_cnt), 64'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("t6_ext_empty", 64'(bus.sum_out_valid), 64'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

        rand_phase(250);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3 reset = 1'b0;
        idle_inputs();
        #1;
        chk("arst_sfp_out", 64'(bus.sfp_out == '0), 64'd1);
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_dz", 64'(bus.dz_flag), 64'd0);
        chk("arst_div_err", 64'(bus.div_err), 64'd0);
        chk("arst_ovf", 64'(bus.ovf), 64'd0);
        chk("arst_sum_out", 64'(bus.sum_out), 64'd0);
        chk("arst_sum_out_valid", 64'(bus.sum_out_valid), 64'd0);
        model_clear();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_rel_ready", 64'(bus.acc_ready), 64'd1);
        chk("arst_rel_sov", 64'(bus.sum_out_valid), 64'd0);

        rand_phase(150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sfp_row_norm.md
Name: sfp_row_norm

Overview:
Parametrised next-generation softmax-style row normaliser for the attention datapath, sitting after the MAC-array psum readout.
- Per row: accumulates the lane-wise absolute sum into a local sum FIFO, and exports the same sum to the peer core through an external FIFO.
- Then divides each lane by the scaled two-core sum.
- Adds over the previous generation: parametrised lane count, FIFO depth and shift; signed-output mode; valid/ready flags; divide-by-zero saturation; overflow and error reporting.

Parameters:
COL, 8, lane count
BW, 8, operand width
BW_PSUM, 2*BW+4, per-lane psum width (two's complement)
SHIFT, 7, right shift applied to each core sum before adding
DEPTH, 16, depth of each sum FIFO (power of two, >=2)
SUM_W, BW_PSUM+clog2(COL), derived localparam, width of a lane-abs sum

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
acc  in  1  accumulate request; sfp_in is valid this cycle
div  in  1  divide request; sfp_in is valid this cycle
sign_mode  in  1  1 = output keeps input sign; 0 = unsigned magnitude
sfp_in  in  COL*BW_PSUM  lane psums, lane 0 in the LSBs
sum_in  in  SUM_W  peer core's sum
sum_in_valid  in  1  sum_in is valid
ext_rd  in  1  peer pops the external FIFO
sum_out  out  SUM_W  head of the external FIFO (first-word fall-through)
sum_out_valid  out  1  external FIFO not empty
acc_ready  out  1  both FIFOs not full
sfp_out  out  COL*BW_PSUM  normalised lanes, registered
out_valid  out  1  sfp_out updated on this cycle
dz_flag  out  1  last division had a zero denominator
div_err  out  1  one-cycle pulse: div rejected
ovf  out  1  sticky: an acc was dropped

Behaviour:
- Reset (reset=0, asynchronous, effective mid-operation):
  - FIFOs emptied; sfp_out, out_valid, dz_flag, div_err, ovf = 0; sum_out = 0.
  - acc_ready = 1 after reset.
- Lane magnitude: abs_i = |sfp_in_i| as unsigned BW_PSUM bits. -2^(BW_PSUM-1) maps exactly to 2^(BW_PSUM-1).
- Accumulate:
  - When acc=1 and acc_ready=1, S = sum of abs_i (SUM_W bits, no overflow) is pushed into both FIFOs on the same edge.
  - When acc=1 and acc_ready=0, nothing is pushed and ovf is set; ovf clears only on reset.
- Divide:
  - Accepted when div=1, the local FIFO is not empty and sum_in_valid=1. On acceptance the local head is popped and D = (local_head>>SHIFT) + (sum_in>>SHIFT).
  - Results register on that edge; out_valid=1 the following cycle only (latency 1).
  - If D != 0: lane quotient q_i = abs_i / D, floor, unsigned.
  - If D = 0: q_i = 2^(BW_PSUM-1)-1 when abs_i != 0, else 0; dz_flag=1 (dz_flag is updated on every accepted div).
  - Output per lane: sign_mode=1 and input negative -> -q_i in two's complement; otherwise q_i.
  - When div=1 but the request is not accepted: no pop, out_valid stays 0, div_err=1 for one cycle, sfp_out holds.
- Simultaneous acc and div in one cycle: both are performed.
  - The pop sees the pre-push contents; there is no bypass.
  - An empty FIFO plus acc+div gives the push and a div_err.
  - Full FIFO plus acc+div: the push is still rejected (acc_ready is evaluated before the pop).
- External FIFO:
  - ext_rd with sum_out_valid=1 pops.
  - ext_rd while empty is ignored.
  - Push and pop in the same cycle are allowed at any occupancy except push-when-full.
- FIFO pointers wrap modulo DEPTH; occupancy counter is 0..DEPTH.
- sfp_out holds its value between accepted divides.

Decomposition:
- Package sfp_pkg:
  - clog2 function and SUM_W derivation.
  - Saturation constant 2^(BW_PSUM-1)-1.
  - Lane slice helper indices.
- Sub-module sfp_sum_fifo:
  - Parametrised width/depth, FWFT, asynchronous active-low reset.
  - Outputs empty, full, count.
  - Instantiated twice (local and external).
- Lane abs/divide/sign logic as a generate loop in the top.

Test Plan (COL=8, BW_PSUM=20, SHIFT=7, DEPTH=16):
1. Reset asserted asynchronously mid-cycle -> all outputs 0 immediately; after release acc_ready=1, sum_out_valid=0.
2. acc with all lanes 1024 except lane3 = -1024 -> sum_out=8192, sum_out_valid=1. Next cycle div with same sfp_in, sum_in=8192, sign_mode=1 -> D=128; next cycle out_valid=1, lanes=8, lane3=-8 (0xFFFF8), dz_flag=0. With sign_mode=0, lane3=8.
3. Local sum 100, sum_in=100 (D=0), lane0=5, others 0 -> lane0=524287, others 0, dz_flag=1.
4. 16 accs with no pops -> acc_ready=0. 17th acc dropped, ovf=1. Subsequent divs pop sums in push order (FIFO ordering and wrap).
5. div with local FIFO empty -> div_err pulse, out_valid=0. div with sum_in_valid=0 and FIFO non-empty -> div_err, count unchanged.
6. All lanes -524288 -> S=4194304. acc+div same cycle on an empty FIFO -> push plus div_err. Subsequent ext_rd pops, sum_out_valid drops to 0 after the last pop.
